// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with a one-word output register (optional parity via UART_RX_PARITY_EN).
// Latency: word presented two cycles after the last stop-bit sample (synchroniser adds 2-3 cycles on the line).
// Backpressure: holds one word; a frame completing while the word is unaccepted is dropped and flagged by rx_overrun.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sclk_100M,
    input  logic                 s_rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_ferr,
    output logic                 rx_perr,
    output logic                 rx_overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam int CW           = $clog2(DATA_BITS + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_chk_baud
            $error("uart_rx_param: CLK_FREQ/BAUD_RATE must be at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data
            $error("uart_rx_param: DATA_BITS must be 5..8");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
            $error("uart_rx_param: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                 state;
    logic                   sync1;
    logic                   sync2;
    logic                   sync3;
    logic [BW-1:0]          baud_cnt;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   ferr_acc;
    logic                   done;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = PARITY_ODD[0];
    logic                   par_bit;
`endif

    // Line synchroniser; reset to the idle level so release never fakes a start edge.
    always_ff @(posedge sclk_100M) begin
        if (!s_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge sclk_100M) begin
        if (!s_rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            ferr_acc <= 1'b0;
            done     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sync2 && sync3) begin
                        state    <= START;
                        baud_cnt <= '0;
                        ferr_acc <= 1'b0;
                    end
                end
                // Half-bit check of the start bit rejects glitches shorter than half a bit.
                START: begin
                    if (baud_cnt == BAUD_HALF) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= sync2 ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {sync2, shift[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        par_bit  <= sync2;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                // Return to IDLE at the middle of the last stop bit so a back-to-back start is caught.
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (!sync2) begin
                            ferr_acc <= 1'b1;
                        end
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            done    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output holding register; shift/ferr_acc/par_bit are still intact during the done cycle.
    always_ff @(posedge sclk_100M) begin
        if (!s_rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_perr    <= 1'b0;
`endif
        end else begin
            rx_overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_ferr  <= ferr_acc;
                    rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    rx_perr  <= ((^shift) ^ par_bit) != PAR_SENSE;
`endif
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign rx_perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at default parameters with a frame-level scoreboard.
module tb_uart_rx_param;

    localparam int CPB = 100_000_000 / 115200;
    localparam int PO  = 0;

    logic       sclk_100M = 1'b0;
    logic       s_rst_n   = 1'b0;
    logic       rx        = 1'b1;
    logic       rx_ready  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_perr;
    logic       rx_overrun;

    uart_rx_param #(
        .CLK_FREQ  (100_000_000),
        .BAUD_RATE (115200),
        .DATA_BITS (8),
        .STOP_BITS (1),
        .PARITY_ODD(PO)
    ) dut (
        .sclk_100M (sclk_100M),
        .s_rst_n   (s_rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_ferr   (rx_ferr),
        .rx_perr   (rx_perr),
        .rx_overrun(rx_overrun)
    );

    always #5 sclk_100M = ~sclk_100M;

    typedef struct packed {
        logic [7:0] d;
        logic       ferr;
        logic       perr;
    } word_t;

    word_t exp_q[$];
    int    n_checks    = 0;
    int    n_pass      = 0;
    int    accepted    = 0;
    int    ovr_pulses  = 0;
    logic  hold_prev   = 1'b0;
    logic  ovr_prev    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Parity bit actually placed on the line; negative request means a correct one.
    function automatic logic line_par(input logic [7:0] d, input int pbit);
        if (pbit < 0) return logic'(($countones(d) + PO) % 2);
        return pbit[0];
    endfunction

    function automatic word_t mk(input logic [7:0] d, input logic stop_v, input int pbit);
        word_t w;
        w.d    = d;
        w.ferr = ~stop_v;
`ifdef UART_RX_PARITY_EN
        w.perr = ((($countones(d) + int'(line_par(d, pbit))) % 2) != PO);
`else
        w.perr = 1'b0;
`endif
        return w;
    endfunction

    task automatic bit_out(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(posedge sclk_100M);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int pbit);
        bit_out(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_out(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        bit_out(line_par(d, pbit), CPB);
`endif
        bit_out(stop_v, CPB);
        rx = 1'b1;
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(posedge sclk_100M); #1;
        rx_ready = 1'b0;
    endtask

    // Scoreboard: the held word must always equal the oldest expected frame.
    always @(negedge sclk_100M) begin
        if (!s_rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
            ovr_prev  = 1'b0;
        end else begin
            if (hold_prev) check("valid_held", rx_valid, 1);
            if (rx_overrun) begin
                ovr_pulses++;
                check("ovr_one_cycle", ovr_prev, 0);
            end
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", rx_valid, 0);
                end else begin
                    check("sb_data", rx_data, exp_q[0].d);
                    check("sb_ferr", rx_ferr, exp_q[0].ferr);
                    check("sb_perr", rx_perr, exp_q[0].perr);
                    if (rx_ready) begin
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
            end
            hold_prev = rx_valid && !rx_ready;
            ovr_prev  = rx_overrun;
        end
    end

    initial begin
        repeat (3) @(posedge sclk_100M);
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ferr", rx_ferr, 0);
        check("rst_perr", rx_perr, 0);
        check("rst_overrun", rx_overrun, 0);
        s_rst_n = 1'b1;
        repeat (20) @(posedge sclk_100M);
        #1;

        // 0x55, held until a single-cycle ready
        exp_q.push_back(mk(8'h55, 1'b1, -1));
        send_frame(8'h55, 1'b1, -1);
        repeat (100) @(posedge sclk_100M);
        #1;
        check("d55_data", rx_data, 8'h55);
        check("d55_valid", rx_valid, 1);
        check("d55_ferr", rx_ferr, 0);
        pulse_ready();
        check("d55_valid_cleared", rx_valid, 0);

        // Start-bit glitch must be rejected, receiver idle again in time for the next frame
        bit_out(1'b0, 200);
        bit_out(1'b1, 300);
        check("glitch_no_valid", rx_valid, 0);
        rx_ready = 1'b1;
        exp_q.push_back(mk(8'h3C, 1'b1, -1));
        send_frame(8'h3C, 1'b1, -1);
        repeat (20) @(posedge sclk_100M);
        #1;
        check("acc_after_3c", accepted, 2);
        rx_ready = 1'b0;

        // Back-to-back frames with no consumer: second is dropped
        exp_q.push_back(mk(8'h11, 1'b1, -1));
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        repeat (50) @(posedge sclk_100M);
        #1;
        check("ovr_count", ovr_pulses, 1);
        check("ovr_kept_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        pulse_ready();
        check("acc_after_11", accepted, 3);

        // Framing error is delivered with its data
        exp_q.push_back(mk(8'hA3, 1'b0, -1));
        send_frame(8'hA3, 1'b0, -1);
        repeat (50) @(posedge sclk_100M);
        #1;
        check("a3_data", rx_data, 8'hA3);
        check("a3_valid", rx_valid, 1);
        check("a3_ferr", rx_ferr, 1);

        // Reset in the middle of data bit 3 of 0xC3, with 0xA3 still held
        bit_out(1'b0, CPB);
        bit_out(1'b1, CPB);
        bit_out(1'b1, CPB);
        bit_out(1'b0, CPB);
        bit_out(1'b0, CPB / 2);
        s_rst_n = 1'b0;
        @(posedge sclk_100M);
        #1;
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_ferr", rx_ferr, 0);
        check("mid_rst_perr", rx_perr, 0);
        check("mid_rst_overrun", rx_overrun, 0);
        s_rst_n = 1'b1;
        bit_out(1'b1, 2 * CPB);
        check("post_rst_idle", rx_valid, 0);
        rx_ready = 1'b1;
        exp_q.push_back(mk(8'hC3, 1'b1, -1));
        send_frame(8'hC3, 1'b1, -1);
        repeat (20) @(posedge sclk_100M);
        #1;
        check("acc_after_c3", accepted, 4);
        rx_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity bit 0 is wrong for even sense, 1 is right
        exp_q.push_back(mk(8'h07, 1'b1, 0));
        send_frame(8'h07, 1'b1, 0);
        repeat (50) @(posedge sclk_100M);
        #1;
        check("p07_bad_perr", rx_perr, 1);
        pulse_ready();
        exp_q.push_back(mk(8'h07, 1'b1, 1));
        send_frame(8'h07, 1'b1, 1);
        repeat (50) @(posedge sclk_100M);
        #1;
        check("p07_good_perr", rx_perr, 0);
        pulse_ready();
        check("acc_after_par", accepted, 6);
`endif

        repeat (10) @(posedge sclk_100M);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("ovr_total", ovr_pulses, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
